// File: rtl/mba_instr_mem_ctrl.sv
// Instruction/data memory controller: banked SRAM plus boot ROM behind one request/response port.
// One response per accepted request; a stalled response is frozen in a hold register.
module mba_instr_mem_ctrl #(
    parameter int RAM_SIZE       = 32768,
    parameter int NUM_BANKS      = 2,
    parameter int BOOT_ADDR_BITS = 12,
    parameter int ADDR_WIDTH     = $clog2(RAM_SIZE) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [31:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    output logic [NUM_BANKS-1:0]      mem_csb0_o,
    output logic                      mem_web0_o,
    output logic [3:0]                mem_wmask0_o,
    output logic [31:0]               mem_addr0_o,
    output logic [31:0]               mem_din0_o,
    input  logic [32*NUM_BANKS-1:0]   mem_dout0_i,
    output logic [NUM_BANKS-1:0]      mem_csb1_o,
    output logic [31:0]               mem_addr1_o,
    output logic                      rom_en_o,
    output logic [BOOT_ADDR_BITS-1:0] rom_addr_o,
    input  logic [31:0]               rom_rdata_i
);

    localparam int BANK_BITS  = $clog2(NUM_BANKS);
    localparam int BIDX_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int WORD_BITS  = ADDR_WIDTH - 3;
    localparam int BWORD_BITS = WORD_BITS - BANK_BITS;

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    state_t              state_reg;
    logic                ready_q;
    logic [BIDX_W-1:0]   resp_bank_reg;
    logic                resp_boot_reg;
    logic                resp_we_reg;
    logic                resp_err_reg;
    logic [31:0]         hold_data_reg;
    logic                hold_err_reg;

    logic                is_boot;
    logic                ram_acc;
    logic [BIDX_W-1:0]   bank_sel;
    logic [BWORD_BITS-1:0] bank_word;
    logic [31:0]         bank_dout [2**BIDX_W];
    logic [31:0]         live_data;
    logic                unused_addr_bits;

    assign is_boot          = addr_i[ADDR_WIDTH-1];
    assign bank_word        = addr_i[BWORD_BITS+1:2];
    assign unused_addr_bits = ^addr_i[1:0];

    generate
        if (BANK_BITS > 0) begin : g_multi_bank
            assign bank_sel = addr_i[ADDR_WIDTH-2 -: BANK_BITS];
        end else begin : g_single_bank
            assign bank_sel = '0;
        end
    endgenerate

    // Stall blocks new grants so the outstanding response is never overwritten.
    assign rvalid_o = (state_reg != IDLE);
    assign gnt_o    = req_i & ready_q & ~(rvalid_o & ~rready_i);
    assign ram_acc  = gnt_o & ~is_boot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_csb
            localparam logic [BIDX_W-1:0] BIDX = BIDX_W'(gi);
            assign mem_csb0_o[gi] = ~(ram_acc && (bank_sel == BIDX));
        end
        for (gi = 0; gi < 2**BIDX_W; gi++) begin : g_dout
            if (gi < NUM_BANKS) begin : g_real
                assign bank_dout[gi] = mem_dout0_i[32*gi +: 32];
            end else begin : g_pad
                assign bank_dout[gi] = '0;
            end
        end
    endgenerate

    assign mem_web0_o   = ~(ram_acc & we_i);
    assign mem_wmask0_o = be_i;
    assign mem_din0_o   = wdata_i;
    assign mem_addr0_o  = {{(32-BWORD_BITS){1'b0}}, bank_word};
    assign mem_csb1_o   = '1;
    assign mem_addr1_o  = '0;
    assign rom_en_o     = gnt_o & is_boot & ~we_i;
    assign rom_addr_o   = addr_i[BOOT_ADDR_BITS-1:0];

    // Writes (including rejected boot writes) always answer with zero data.
    always_comb begin
        live_data = '0;
        if (!resp_we_reg) begin
            live_data = resp_boot_reg ? rom_rdata_i : bank_dout[resp_bank_reg];
        end
    end

    always_comb begin
        rdata_o = '0;
        err_o   = 1'b0;
        case (state_reg)
            RESP: begin
                rdata_o = live_data;
                err_o   = resp_err_reg;
            end
            HOLD: begin
                rdata_o = hold_data_reg;
                err_o   = hold_err_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ready_q       <= 1'b0;
            resp_bank_reg <= '0;
            resp_boot_reg <= 1'b0;
            resp_we_reg   <= 1'b0;
            resp_err_reg  <= 1'b0;
            hold_data_reg <= '0;
            hold_err_reg  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (gnt_o) begin
                resp_bank_reg <= bank_sel;
                resp_boot_reg <= is_boot;
                resp_we_reg   <= we_i;
                resp_err_reg  <= is_boot & we_i;
            end
            case (state_reg)
                IDLE: if (gnt_o) state_reg <= RESP;
                RESP: begin
                    if (!rready_i) begin
                        state_reg     <= HOLD;
                        hold_data_reg <= live_data;
                        hold_err_reg  <= resp_err_reg;
                    end else begin
                        state_reg <= gnt_o ? RESP : IDLE;
                    end
                end
                HOLD: if (rready_i) state_reg <= gnt_o ? RESP : IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mba_instr_mem_ctrl.sv
// Directed bench for mba_instr_mem_ctrl with behavioural SRAM banks and boot ROM.
// SRAM read data encodes bank and word address so ordering and routing are visible.
module tb_mba_instr_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic [15:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [1:0]  mem_csb0_o;
    logic        mem_web0_o;
    logic [3:0]  mem_wmask0_o;
    logic [31:0] mem_addr0_o;
    logic [31:0] mem_din0_o;
    logic [63:0] mem_dout0_i;
    logic [1:0]  mem_csb1_o;
    logic [31:0] mem_addr1_o;
    logic        rom_en_o;
    logic [11:0] rom_addr_o;
    logic [31:0] rom_rdata_i;

    logic [31:0] dout_q [2];
    logic        scramble;
    int          n_chk = 0;
    int          n_fail = 0;

    mba_instr_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rready_i(rready_i), .rdata_o(rdata_o), .err_o(err_o),
        .mem_csb0_o(mem_csb0_o), .mem_web0_o(mem_web0_o), .mem_wmask0_o(mem_wmask0_o),
        .mem_addr0_o(mem_addr0_o), .mem_din0_o(mem_din0_o), .mem_dout0_i(mem_dout0_i),
        .mem_csb1_o(mem_csb1_o), .mem_addr1_o(mem_addr1_o), .rom_en_o(rom_en_o),
        .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata_i)
    );

    always #5 clk = ~clk;

    // SRAM read: data valid the cycle after the select; content = A<bank>_<word addr>.
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!mem_csb0_o[b] && mem_web0_o)
                dout_q[b] <= 32'hA000_0000 | (32'(b) << 24) | {8'h00, mem_addr0_o[23:0]};
        end
        if (rom_en_o) rom_rdata_i <= 32'hC0DE_0000 | {20'h0, rom_addr_o};
    end

    assign mem_dout0_i = {dout_q[1], dout_q[0]} ^ {64{scramble}};

    task automatic test_reset();
        rst_n = 1'b0; req_i = 1'b1; addr_i = 16'h4000; we_i = 1'b0; be_i = 4'hF;
        wdata_i = 32'h0; rready_i = 1'b1; scramble = 1'b0;
        #1;
        n_chk++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL rst_gnt got=%h exp=0", gnt_o); end
        n_chk++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got=%h exp=0", rvalid_o); end
        n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", rdata_o); end
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%h exp=0", err_o); end
        n_chk++; if (mem_csb0_o !== 2'b11) begin n_fail++; $display("FAIL rst_csb0 got=%b exp=11", mem_csb0_o); end
        n_chk++; if (mem_csb1_o !== 2'b11) begin n_fail++; $display("FAIL rst_csb1 got=%b exp=11", mem_csb1_o); end
        n_chk++; if (mem_web0_o !== 1'b1) begin n_fail++; $display("FAIL rst_web0 got=%h exp=1", mem_web0_o); end
        n_chk++; if (rom_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_rom_en got=%h exp=0", rom_en_o); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; req_i = 1'b0;
        @(posedge clk); #1;
        $display("reset: released");
    endtask

    task automatic test_ram_read();
        req_i = 1'b1; addr_i = 16'h4000; we_i = 1'b0; rready_i = 1'b1; #1;
        n_chk++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL rd_gnt got=%h exp=1", gnt_o); end
        n_chk++; if (mem_csb0_o !== 2'b01) begin n_fail++; $display("FAIL rd_csb0 got=%b exp=01", mem_csb0_o); end
        n_chk++; if (mem_addr0_o !== 32'h0) begin n_fail++; $display("FAIL rd_addr0 got=%h exp=0", mem_addr0_o); end
        n_chk++; if (mem_web0_o !== 1'b1) begin n_fail++; $display("FAIL rd_web0 got=%h exp=1", mem_web0_o); end
        n_chk++; if (mem_addr1_o !== 32'h0) begin n_fail++; $display("FAIL rd_addr1 got=%h exp=0", mem_addr1_o); end
        @(posedge clk); #1; req_i = 1'b0; #1;
        n_chk++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid got=%h exp=1", rvalid_o); end
        n_chk++; if (rdata_o !== 32'hA100_0000) begin n_fail++; $display("FAIL rd_rdata got=%h exp=a1000000", rdata_o); end
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rd_err got=%h exp=0", err_o); end
        @(posedge clk); #1;
        n_chk++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rd_idle_rvalid got=%h exp=0", rvalid_o); end
        n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rd_idle_rdata got=%h exp=0", rdata_o); end
        $display("ram read 0x4000 done");
    endtask

    task automatic test_ram_write();
        req_i = 1'b1; addr_i = 16'h0010; we_i = 1'b1; be_i = 4'b0011; wdata_i = 32'hDEADBEEF; #1;
        n_chk++; if (mem_csb0_o !== 2'b10) begin n_fail++; $display("FAIL wr_csb0 got=%b exp=10", mem_csb0_o); end
        n_chk++; if (mem_web0_o !== 1'b0) begin n_fail++; $display("FAIL wr_web0 got=%h exp=0", mem_web0_o); end
        n_chk++; if (mem_wmask0_o !== 4'b0011) begin n_fail++; $display("FAIL wr_wmask got=%b exp=0011", mem_wmask0_o); end
        n_chk++; if (mem_addr0_o !== 32'h4) begin n_fail++; $display("FAIL wr_addr0 got=%h exp=4", mem_addr0_o); end
        n_chk++; if (mem_din0_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_din got=%h exp=deadbeef", mem_din0_o); end
        @(posedge clk); #1; req_i = 1'b0; we_i = 1'b0; be_i = 4'hF; #1;
        n_chk++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL wr_rvalid got=%h exp=1", rvalid_o); end
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL wr_err got=%h exp=0", err_o); end
        n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL wr_rdata got=%h exp=0", rdata_o); end
        @(posedge clk); #1;
        $display("ram write 0x10 done");
    endtask

    task automatic test_boot();
        req_i = 1'b1; addr_i = 16'h8ABC; we_i = 1'b0; #1;
        n_chk++; if (rom_en_o !== 1'b1) begin n_fail++; $display("FAIL boot_rom_en got=%h exp=1", rom_en_o); end
        n_chk++; if (rom_addr_o !== 12'hABC) begin n_fail++; $display("FAIL boot_rom_addr got=%h exp=abc", rom_addr_o); end
        n_chk++; if (mem_csb0_o !== 2'b11) begin n_fail++; $display("FAIL boot_csb0 got=%b exp=11", mem_csb0_o); end
        @(posedge clk); #1; we_i = 1'b1; #1;
        n_chk++; if (rdata_o !== 32'hC0DE_0ABC) begin n_fail++; $display("FAIL boot_rdata got=%h exp=c0de0abc", rdata_o); end
        n_chk++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL bootwr_gnt got=%h exp=1", gnt_o); end
        n_chk++; if (rom_en_o !== 1'b0) begin n_fail++; $display("FAIL bootwr_rom_en got=%h exp=0", rom_en_o); end
        n_chk++; if (mem_csb0_o !== 2'b11) begin n_fail++; $display("FAIL bootwr_csb0 got=%b exp=11", mem_csb0_o); end
        n_chk++; if (mem_web0_o !== 1'b1) begin n_fail++; $display("FAIL bootwr_web0 got=%h exp=1", mem_web0_o); end
        @(posedge clk); #1; req_i = 1'b0; we_i = 1'b0; #1;
        n_chk++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL bootwr_rvalid got=%h exp=1", rvalid_o); end
        n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL bootwr_err got=%h exp=1", err_o); end
        n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL bootwr_rdata got=%h exp=0", rdata_o); end
        @(posedge clk); #1;
        $display("boot read/write 0x8abc done");
    endtask

    task automatic test_stall();
        req_i = 1'b1; addr_i = 16'h4000; we_i = 1'b0; rready_i = 1'b0; #1;
        n_chk++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL st_gnt got=%h exp=1", gnt_o); end
        @(posedge clk); #1; addr_i = 16'h0000; #1;
        n_chk++; if (rdata_o !== 32'hA100_0000) begin n_fail++; $display("FAIL st_resp_rdata got=%h exp=a1000000", rdata_o); end
        n_chk++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL st_resp_gnt got=%h exp=0", gnt_o); end
        n_chk++; if (mem_csb0_o !== 2'b11) begin n_fail++; $display("FAIL st_resp_csb0 got=%b exp=11", mem_csb0_o); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1; scramble = ~scramble; #1;
            n_chk++; if (rdata_o !== 32'hA100_0000) begin n_fail++; $display("FAIL st_hold_rdata[%0d] got=%h exp=a1000000", k, rdata_o); end
            n_chk++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL st_hold_rvalid[%0d] got=%h exp=1", k, rvalid_o); end
            n_chk++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL st_hold_gnt[%0d] got=%h exp=0", k, gnt_o); end
        end
        scramble = 1'b0; rready_i = 1'b1; addr_i = 16'h0008; #1;
        n_chk++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL st_retire_gnt got=%h exp=1", gnt_o); end
        n_chk++; if (mem_csb0_o !== 2'b10) begin n_fail++; $display("FAIL st_retire_csb0 got=%b exp=10", mem_csb0_o); end
        n_chk++; if (rdata_o !== 32'hA100_0000) begin n_fail++; $display("FAIL st_retire_rdata got=%h exp=a1000000", rdata_o); end
        @(posedge clk); #1; req_i = 1'b0; #1;
        n_chk++; if (rdata_o !== 32'hA000_0002) begin n_fail++; $display("FAIL st_next_rdata got=%h exp=a0000002", rdata_o); end
        @(posedge clk); #1;
        n_chk++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL st_idle_rvalid got=%h exp=0", rvalid_o); end
        $display("stall 3 cycles then retire with grant done");
    endtask

    task automatic test_back_to_back();
        int grants = 0;
        logic [31:0] exp_data;
        rready_i = 1'b1; we_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_i = 1'b1; addr_i = 16'(((i % 2) << 14) | ((i + 1) << 2)); #1;
            if (gnt_o === 1'b1) grants++;
            n_chk++; if (mem_csb0_o !== ((i % 2 == 1) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL b2b_csb0[%0d] got=%b", i, mem_csb0_o); end
            if (i > 0) begin
                exp_data = 32'hA000_0000 | (32'((i - 1) % 2) << 24) | 32'(i);
                n_chk++; if (rdata_o !== exp_data) begin n_fail++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i - 1, rdata_o, exp_data); end
            end
            @(posedge clk); #1;
        end
        req_i = 1'b0; #1;
        n_chk++; if (rdata_o !== 32'hA100_0008) begin n_fail++; $display("FAIL b2b_rdata[7] got=%h exp=a1000008", rdata_o); end
        n_chk++; if (grants != 8) begin n_fail++; $display("FAIL b2b_grants got=%0d exp=8", grants); end
        @(posedge clk); #1;
        $display("back-to-back 8 reads: %0d grants", grants);
    endtask

    task automatic test_reset_in_hold();
        req_i = 1'b1; addr_i = 16'h4000; we_i = 1'b0; rready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rh_pre_rvalid got=%h exp=1", rvalid_o); end
        rst_n = 1'b0; #1;
        n_chk++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rh_rvalid got=%h exp=0", rvalid_o); end
        n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rh_rdata got=%h exp=0", rdata_o); end
        n_chk++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL rh_gnt got=%h exp=0", gnt_o); end
        n_chk++; if (mem_csb0_o !== 2'b11) begin n_fail++; $display("FAIL rh_csb0 got=%b exp=11", mem_csb0_o); end
        @(negedge clk); rst_n = 1'b1; rready_i = 1'b1; #1;
        n_chk++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL rh_rel_gnt got=%h exp=0", gnt_o); end
        n_chk++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rh_rel_rvalid got=%h exp=0", rvalid_o); end
        @(posedge clk); #1;
        n_chk++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL rh_ready_gnt got=%h exp=1", gnt_o); end
        n_chk++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rh_ready_rvalid got=%h exp=0", rvalid_o); end
        @(posedge clk); #1; req_i = 1'b0; #1;
        n_chk++; if (rdata_o !== 32'hA100_0000) begin n_fail++; $display("FAIL rh_new_rdata got=%h exp=a1000000", rdata_o); end
        @(posedge clk); #1;
        $display("reset during hold done");
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_ram_write();
        test_boot();
        test_stall();
        test_back_to_back();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mba_instr_mem_ctrl.md
MBA_INSTR_MEM_CTRL -- requirements
Module: mba_instr_mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 32768, SRAM capacity in bytes (power of two).
REQ-002 SHALL have parameter NUM_BANKS, default 2, number of SRAM macros (power of two, 1..8); each bank holds RAM_SIZE/NUM_BANKS bytes.
REQ-003 SHALL have parameter BOOT_ADDR_BITS, default 12, boot ROM byte-address width.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(RAM_SIZE)+1; MSB selects the boot region.
REQ-005 SHALL have ports: clk input 1, clock (all logic on rising edge).
REQ-006 rst_n input 1, asynchronous active-low reset.
REQ-007 req_i input 1, request; addr_i input ADDR_WIDTH, byte address; we_i input 1, write; be_i input 4, byte enables; wdata_i input 32, write data.
REQ-008 gnt_o output 1, request accepted this cycle.
REQ-009 rvalid_o output 1, response valid; rready_i input 1, response consumed; rdata_o output 32, read data; err_o output 1, response error.
REQ-010 mem_csb0_o output NUM_BANKS, per-bank port-0 select, active low; mem_web0_o output 1, write enable, active low; mem_wmask0_o output 4; mem_addr0_o output 32, bank word address zero-extended; mem_din0_o output 32; mem_dout0_i input 32*NUM_BANKS, bank b at bits [32b+31:32b]; mem_csb1_o output NUM_BANKS, port-1 select; mem_addr1_o output 32.
REQ-011 rom_en_o output 1; rom_addr_o output BOOT_ADDR_BITS; rom_rdata_i input 32; ROM data valid one cycle after rom_en_o.

Function
REQ-012 is_boot = addr_i[ADDR_WIDTH-1]; RAM word address w = addr_i[ADDR_WIDTH-2:2]; bank = upper log2(NUM_BANKS) bits of w; bank word address = remaining lower bits; addr_i[1:0] ignored.
REQ-013 ready_q register: 0 in reset, 1 from the first clk edge after rst_n deasserts; gnt_o = req_i & ready_q & ~(rvalid_o & ~rready_i).
REQ-014 Accepted RAM access (gnt_o=1, is_boot=0): the selected bank's mem_csb0_o bit is 0 in the same cycle; all other bits 1; mem_web0_o = ~we_i; mem_wmask0_o = be_i; mem_din0_o = wdata_i.
REQ-015 No accepted RAM access: all mem_csb0_o bits 1 and mem_web0_o 1.
REQ-016 mem_csb1_o SHALL be all ones and mem_addr1_o zero at all times.
REQ-017 Accepted boot read: rom_en_o=1 and rom_addr_o=addr_i[BOOT_ADDR_BITS-1:0] in the same cycle; no SRAM select.
REQ-018 Accepted boot write: no ROM or SRAM access; response carries err_o=1, rdata_o=0.
REQ-019 Every accepted request produces exactly one response; rvalid_o=1 in the cycle after acceptance; responses in acceptance order.
REQ-020 Response source (bank index, boot, write, error) registered at acceptance; read data from the selected mem_dout0_i slice or rom_rdata_i; write response rdata_o=0, err_o=0.
REQ-021 rvalid_o & rready_i: response retires; a new request may be granted the same cycle (throughput one per cycle).
REQ-022 rvalid_o & ~rready_i: data from the first response cycle captured into a hold register; rdata_o and err_o driven from it, stable until retired; gnt_o=0, no memory selects.
REQ-023 State: IDLE (no response), RESP (first response cycle, macro data), HOLD (stalled, hold data); IDLE->RESP on grant; RESP->RESP on retire+grant; RESP->IDLE on retire without grant; RESP->HOLD on ~rready_i; HOLD->RESP/IDLE on retire with/without grant.
REQ-024 rdata_o and err_o are 0 whenever rvalid_o=0.

Reset
REQ-025 While rst_n=0: rvalid_o=0, err_o=0, rdata_o=0, gnt_o=0, rom_en_o=0, all mem_csb0_o/mem_csb1_o bits 1, mem_web0_o=1, state IDLE, hold register 0.
REQ-026 Reset asserted mid-response discards the response; after release no rvalid_o until a new grant.

Verification
REQ-027 Read addr 0x0000_4000 (NUM_BANKS=2), rready_i=1 -> mem_csb0_o=2'b01, mem_addr0_o=0; next cycle rvalid_o=1, rdata_o=bank-1 dout.
REQ-028 Write addr 0x10, be_i=4'b0011, wdata_i=0xDEADBEEF -> csb0=2'b10, web0=0, wmask0=4'b0011, addr0=4; next cycle rvalid_o=1, err_o=0, rdata_o=0.
REQ-029 Read 0x8000_0ABC-equivalent boot address (MSB=1) -> rom_en_o=1, rom_addr_o=12'hABC; next cycle rdata_o=rom_rdata_i; boot write -> err_o=1, no selects.
REQ-030 Read with rready_i=0 for 3 cycles while mem_dout0_i changes -> rdata_o holds first-cycle value, gnt_o=0 throughout; retire with req_i=1 -> grant same cycle.
REQ-031 Back-to-back 8 reads, rready_i=1 -> 8 grants in 8 cycles, 8 in-order responses.
REQ-032 rst_n pulsed low during HOLD -> outputs at reset values immediately; gnt_o=0 in the first cycle after release, 1 thereafter with req_i=1.
